instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch front end that produces the 16-bit op word consumed by the data-selector controller and the rest of the decode logic. It holds the PC and issues requests to instruction memory over a req/ack handshake. It latches the returned word into an instruction register and presents it downstream with a valid/ready handshake. Branch redirects from execute replace the PC and squash in-flight or held instructions.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address
DATA_W, 16, width of instruction word (op)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction-memory request, held high until imem_ack
imem_addr  out  ADDR_W  fetch address, valid and stable while imem_req=1
imem_ack  in  1  memory accepts request and returns data this cycle; ignored when imem_req=0
imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1
op  out  DATA_W  instruction register to decode
op_pc  out  ADDR_W  address op was fetched from
op_valid  out  1  op holds an unconsumed instruction
op_ready  in  1  decode accepts op this cycle
redirect  in  1  branch taken; load redirect_pc
redirect_pc  in  ADDR_W  branch target

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on rising edge of clk.
- Reset values: pc=0, op=0, op_pc=0, op_valid=0, imem_req=0, imem_addr=0, state=IDLE, squash=0.
- Reset mid-operation: all of the above take effect on the next edge regardless of an outstanding request; an ack arriving after reset is ignored because imem_req=0.
- States:
  - IDLE: one cycle after reset deassertion; goes to REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_ack=0: stay in REQ.
    - imem_ack=1: capture the word and go to HOLD, unless squash is set or redirect=1 (see below).
  - HOLD: imem_req=0, op_valid=1. When op_valid and op_ready are both 1, clear op_valid and go to REQ.
- Capture on ack: op<=imem_rdata, op_pc<=pc, pc<=pc+1, op_valid<=1.
- Latency: with zero-wait memory (ack in the same cycle as req), op_valid rises 1 cycle after the ack edge. Steady-state throughput is 1 instruction per 2 cycles. Each memory wait cycle adds 1 cycle.
- Squashed ack: if squash=1 when the ack arrives, discard the data, leave op unchanged, keep op_valid=0, clear squash, and stay in REQ with the updated pc.
- Redirect has priority over everything except reset. On redirect=1:
  - pc<=redirect_pc and op_valid<=0; the held op is dropped even if op_ready=1 in the same cycle.
  - REQ with imem_req=1 and no ack: the request cannot be withdrawn. Set squash=1 and hold imem_addr at the old pc until the ack; the next request uses redirect_pc.
  - REQ with ack in the same cycle: discard the data, do not set squash; the next cycle issues REQ at redirect_pc.
  - HOLD or IDLE: go to REQ at redirect_pc.
  - Redirect during squash=1: pc is overwritten and squash stays 1.
- imem_addr equals the pc latched at request start and stays stable while imem_req=1.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000.
- op and op_pc are stable whenever op_valid=1 and there is no handshake or redirect.

Test Plan:
- Reset then zero-wait memory returning rdata=addr^16'hA5A5, op_ready=1 -> imem_addr sequence 0,1,2,3; op 16'hA5A5,16'hA5A4,16'hA5A7; op_valid pulses every 2nd cycle; op_pc matches.
- Memory with 3 wait cycles on addr 0 -> imem_req high and imem_addr=0 stable for 4 cycles; op_valid rises the cycle after the ack.
- op_ready=0 for 5 cycles while op_valid=1 (op=16'hC0C0) -> op held, imem_req=0, pc=1; op_ready=1 -> next request at addr 1.
- Redirect to 16'h0040 while a request to addr 5 is waiting, ack 2 cycles later with 16'h8800 -> 16'h8800 never appears with op_valid=1; next imem_addr=16'h0040.
- Redirect coinciding with op_valid=1 and op_ready=1 -> op_valid=0 next cycle; next fetch at redirect_pc.
- Redirect to 16'hFFFF, two fetches -> imem_addr 16'hFFFF then 16'h0000; reset asserted during a wait -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: holds the PC, requests instruction words from
// memory over a req/ack handshake, and hands each word to decode through a
// valid/ready instruction register. Branch redirects replace the PC and
// discard any instruction that is in flight or waiting to be consumed.
module instruction_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] op,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [ADDR_W-1:0] PC_STEP = 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              squash;

    // A request is outstanding for exactly as long as we sit in REQ.
    assign imem_req = (state == REQ);

    // Fetch sequencing: reset, then redirect, then the normal IDLE/REQ/HOLD
    // flow. imem_addr is reloaded only when a new request starts, so it stays
    // at the old PC while a squashed request is still waiting for its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            op        <= '0;
            op_pc     <= '0;
            op_valid  <= 1'b0;
            imem_addr <= '0;
            squash    <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            op_valid <= 1'b0;
            state    <= REQ;
            if (state == REQ && !imem_ack) begin
                squash <= 1'b1;
            end else begin
                squash    <= 1'b0;
                imem_addr <= redirect_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (squash) begin
                            squash    <= 1'b0;
                            imem_addr <= pc;
                        end else begin
                            op       <= imem_rdata;
                            op_pc    <= pc;
                            pc       <= pc + PC_STEP;
                            op_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        state     <= REQ;
                        imem_addr <= pc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, compared each cycle against a transaction-level model.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] op;
    logic [15:0] op_pc;
    logic        op_valid;
    logic        op_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    int total_checks = 0;
    int passed_checks = 0;

    // Reference model: what the front end is doing in transaction terms.
    bit          m_known = 0;
    bit          m_booting;
    bit          m_fetching;
    bit          m_stale;
    bit          m_holding;
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    logic [15:0] m_op;
    logic [15:0] m_op_pc;

    instruction_fetch #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .op          (op),
        .op_pc       (op_pc),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Compare all DUT outputs against the model (called mid-cycle).
    task automatic compareAll();
        if (m_known) begin
            checkOutput("imem_req", 32'(imem_req), 32'(m_fetching));
            if (m_fetching || m_booting)
                checkOutput("imem_addr", 32'(imem_addr), 32'(m_addr));
            checkOutput("op_valid", 32'(op_valid), 32'(m_holding));
            checkOutput("op", 32'(op), 32'(m_op));
            checkOutput("op_pc", 32'(op_pc), 32'(m_op_pc));
        end
    endtask

    // Advance the model by one clock using the inputs present at that edge.
    task automatic modelEdge(input bit rst, input bit rdy, input bit redir,
                             input logic [15:0] rpc, input bit ack,
                             input logic [15:0] rdata);
        if (rst) begin
            m_known    = 1;
            m_booting  = 1;
            m_fetching = 0;
            m_stale    = 0;
            m_holding  = 0;
            m_pc       = 16'h0000;
            m_addr     = 16'h0000;
            m_op       = 16'h0000;
            m_op_pc    = 16'h0000;
        end else if (redir) begin
            m_pc      = rpc;
            m_holding = 0;
            m_booting = 0;
            if (m_fetching && !ack) begin
                m_stale = 1;
            end else begin
                m_stale    = 0;
                m_fetching = 1;
                m_addr     = rpc;
            end
        end else if (m_booting) begin
            m_booting  = 0;
            m_fetching = 1;
            m_addr     = m_pc;
        end else if (m_fetching && ack) begin
            if (m_stale) begin
                m_stale = 0;
                m_addr  = m_pc;
            end else begin
                m_op       = rdata;
                m_op_pc    = m_pc;
                m_pc       = m_pc + 16'h0001;
                m_holding  = 1;
                m_fetching = 0;
            end
        end else if (m_holding && rdy) begin
            m_holding  = 0;
            m_fetching = 1;
            m_addr     = m_pc;
        end
    endtask

    // One cycle: check outputs, drive inputs, clock, update model.
    task automatic applyStimulus(input bit rst, input bit rdy, input bit redir,
                                 input logic [15:0] rpc, input bit ack,
                                 input logic [15:0] rdata);
        compareAll();
        reset       = rst;
        op_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = rdata;
        @(posedge clk);
        modelEdge(rst, rdy, redir, rpc, ack, rdata);
        @(negedge clk);
    endtask

    // Memory content used by the directed scenarios.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    initial begin
        reset = 1'b1; op_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; imem_ack = 1'b0; imem_rdata = 16'h0000;
        @(negedge clk);

        // Zero-wait memory, decode always ready
        applyStimulus(1, 1, 0, 16'h0, 0, 16'h0);
        applyStimulus(1, 1, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 9; i++)
            applyStimulus(0, 1, 0, 16'h0, 1, memWord(m_addr));

        // Three wait cycles on address 0
        applyStimulus(1, 1, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 1, 0, 16'h0, 1, 16'hDEAD);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 16'h0, 0, 16'hBEEF);
        applyStimulus(0, 1, 0, 16'h0, 1, memWord(m_addr));
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);

        // Decode stalls for 5 cycles on 0xC0C0
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'hC0C0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 16'h0, 1, 16'h1111);
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("addr_after_stall", 32'(imem_addr), 32'h0001);

        // Redirect to 0x0040 while the fetch of address 5 waits
        applyStimulus(1, 1, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 9; i++)
            applyStimulus(0, 1, 0, 16'h0, i % 2 == 0, memWord(m_addr));
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("wait_addr5", 32'(imem_addr), 32'h0005);
        applyStimulus(0, 1, 1, 16'h0040, 0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 16'h0, i == 1, (i == 1) ? 16'h8800 : memWord(m_addr));
            checkOutput("squash_leak", 32'(op_valid && op == 16'h8800), 32'h0);
        end

        // Redirect in the same cycle decode accepts the held op
        applyStimulus(0, 1, 0, 16'h0, 1, memWord(m_addr));
        applyStimulus(0, 1, 1, 16'h0123, 0, 16'h0);
        checkOutput("redirect_drop", 32'(op_valid), 32'h0);
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);

        // Redirect to 0xFFFF, PC wraps, then reset during a wait
        applyStimulus(0, 1, 1, 16'hFFFF, 1, 16'h0);
        checkOutput("wrap_first", 32'(imem_addr), 32'hFFFF);
        applyStimulus(0, 1, 0, 16'h0, 1, memWord(m_addr));
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("wrap_second", 32'(imem_addr), 32'h0000);
        applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
        applyStimulus(1, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("reset_req", 32'(imem_req), 32'h0);
        applyStimulus(0, 1, 0, 16'h0, 1, 16'h7777);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(99) == 0),
                          ($urandom_range(9) < 7),
                          ($urandom_range(11) == 0),
                          16'($urandom),
                          ($urandom_range(1) == 1),
                          16'($urandom));
        end
        compareAll();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
